// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame timing and counter sizing.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS_DEF    = 8;
  localparam int CNT_W            = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic [CNT_W-1:0] cnt_val(input int v);
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/uart_rx_hold.sv
// One-entry output holding register: a completed byte is visible the cycle after the stop sample.
// Backpressure: a byte completing while the entry is full and not being read is dropped and flagged.
module uart_rx_hold
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 overrun
);

  logic accept;

  assign accept = valid & ready;

  // A read in the same cycle as a load frees the entry, so the new byte wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load & valid & ~ready;
      if (load && (!valid || ready)) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: 2-flop sync, mid-bit sampling FSM, one-entry valid/ready output.
// Byte appears the cycle after the stop-bit sample; a byte finishing while the output is full is dropped.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 8) begin : g_param_check
    $error("uart_rx: CLKS_PER_BIT must be >= 4 and DATA_BITS in 5..8");
  end

  localparam logic [CNT_W-1:0] HALF_LAST    = cnt_val(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST     = cnt_val(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_CNT_LAST = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shifter;
  logic                 half_tick;
  logic                 bit_tick;
  logic                 sample_tick;
  logic                 shift_en;
  logic                 frame_done;
  logic                 stop_bad;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  assign half_tick = (clk_cnt == HALF_LAST);
  assign bit_tick  = (clk_cnt == BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_tick && bit_cnt == BIT_CNT_LAST) state_nxt = STOP;
      STOP:    if (bit_tick) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    shift_en    = (state == DATA) && bit_tick;
    frame_done  = (state == STOP) && bit_tick && rx_s;
    stop_bad    = (state == STOP) && bit_tick && !rx_s;
    sample_tick = ((state == START) && half_tick) ||
                  (((state == DATA) || (state == STOP)) && bit_tick);
  end

  // The half-bit first sample aligns every later sample to the middle of its bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_cnt <= '0;
    end else if (state == IDLE || state == BREAK || sample_tick) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (state != DATA) begin
      bit_cnt <= '0;
    end else if (bit_tick) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shifter <= '0;
    end else if (shift_en) begin
      shifter <= {rx_s, shifter[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      framing_err <= 1'b0;
    end else begin
      framing_err <= stop_bad;
    end
  end

  uart_rx_hold #(
    .DATA_BITS (DATA_BITS)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .load      (frame_done),
    .load_data (shifter),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .overrun   (overrun)
  );

endmodule
